data_ram_bank: RTL and testbench

- Parametrised successor of the core's data RAM.
- Single-port, synchronous-read, byte-lane-masked memory behind a valid/ready request/response handshake.
- Sits between the LSU and data-memory storage. Handles byte, half, word (and doubleword when DATA_W=64) stores and loads, with load sign/zero extension and alignment/range error reporting.
- One-cycle read latency and a one-entry response register with backpressure.

---
 rtl/data_ram_bank.sv | 140 ++++++++++++++
 tb/tb_data_ram_bank.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_bank.sv
// data_ram_bank: single-port, byte-lane-masked data RAM with a valid/ready request port
// and a one-entry registered response that holds steady under backpressure.
module data_ram_bank #(
  parameter int              DATA_W     = 32,
  parameter int              DEPTH_LOG2 = 12,
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              dbg_state
);

  // Handshake: a request transfers on a posedge with req_valid && req_ready; a response
  // transfers on a posedge with resp_valid && resp_ready; both may happen on the same edge.

  localparam int BYTES  = DATA_W / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int WORDS  = 1 << DEPTH_LOG2;
  localparam logic [ADDR_W:0] ONE_A     = 1;
  localparam logic [ADDR_W:0] MEM_BYTES = ONE_A << (DEPTH_LOG2 + LANE_W);
  localparam logic [DATA_W-1:0] ONE_D   = 1;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t                  r_state;
  logic                    r_err;
  logic                    r_ld;
  logic [1:0]              r_sz;
  logic                    r_uns;
  logic [LANE_W-1:0]       r_lane;
  logic [DATA_W-1:0]       r_rd_word;
  logic [DATA_W-1:0]       r_mem [WORDS];

  logic [ADDR_W:0]         w_off;
  logic                    w_in_range;
  logic [1:0]              w_sz;
  logic [LANE_W-1:0]       w_lane;
  logic [DEPTH_LOG2-1:0]   w_idx;
  logic                    w_bad_size;
  logic                    w_misal;
  logic                    w_err;
  logic                    w_acc;
  logic [BYTES-1:0]        w_be;
  logic [DATA_W-1:0]       w_wdata_sh;
  logic [DATA_W-1:0]       w_sh;
  logic [DATA_W-1:0]       w_keep;
  logic [6:0]              w_nbits;
  logic                    w_sign;
  logic [DATA_W-1:0]       w_ext;

  assign resp_valid = (r_state == ST_FULL);
  assign req_ready  = !resp_valid || resp_ready;
  assign w_acc      = req_valid && req_ready;
  assign dbg_state  = r_state;

  // A borrow out of the subtraction means the address lies below BASE_ADDR.
  assign w_off      = {1'b0, req_addr} - {1'b0, BASE_ADDR};
  assign w_in_range = !w_off[ADDR_W] && (w_off < MEM_BYTES);
  assign w_sz       = req_size[1:0];
  assign w_lane     = req_addr[LANE_W-1:0];
  assign w_idx      = w_off[LANE_W +: DEPTH_LOG2];
  assign w_bad_size = (req_size == 3'b111) ||
                      ((DATA_W == 32) && ((req_size == 3'b011) || (req_size == 3'b110)));
  assign w_err      = !w_in_range || w_bad_size || w_misal;
  assign w_wdata_sh = req_wdata << {w_lane, 3'b000};

  always_comb begin
    w_misal = 1'b0;
    case (w_sz)
      2'd1:    w_misal = req_addr[0];
      2'd2:    w_misal = |req_addr[1:0];
      2'd3:    w_misal = |req_addr[2:0];
      default: w_misal = 1'b0;
    endcase
  end

  always_comb begin
    w_be = '0;
    for (int b = 0; b < BYTES; b++) begin
      w_be[b] = (b >= int'(w_lane)) && (b < int'(w_lane) + (1 << w_sz));
    end
  end

  // Storage has no reset; errored requests never touch it.
  always_ff @(posedge clk) begin
    if (w_acc && !w_err) begin
      if (req_we) begin
        for (int b = 0; b < BYTES; b++) begin
          if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
        end
      end else begin
        r_rd_word <= r_mem[w_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_err   <= 1'b0;
      r_ld    <= 1'b0;
      r_sz    <= '0;
      r_uns   <= 1'b0;
      r_lane  <= '0;
    end else if (w_acc) begin
      r_state <= ST_FULL;
      r_err   <= w_err;
      r_ld    <= !req_we && !w_err;
      r_sz    <= w_sz;
      r_uns   <= req_size[2];
      r_lane  <= w_lane;
    end else if (resp_ready) begin
      r_state <= ST_EMPTY;
    end
  end

  // Field mask wraps to all ones when the access covers the full data width.
  always_comb begin
    w_sh    = r_rd_word >> {r_lane, 3'b000};
    w_nbits = 7'd8 << r_sz;
    w_keep  = (ONE_D << w_nbits) - ONE_D;
    w_sign  = !r_uns && |(w_sh & (w_keep ^ (w_keep >> 1)));
    w_ext   = (w_sh & w_keep) | ({DATA_W{w_sign}} & ~w_keep);
  end

  assign resp_rdata = r_ld ? w_ext : '0;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_data_ram_bank.sv
// Self-checking bench for data_ram_bank: directed lane/error/backpressure/reset scenarios
// plus randomized traffic against a byte-addressed reference model.
module tb_data_ram_bank;

  localparam logic [31:0] BASE     = 32'h1000_0000;
  localparam longint      SPAN32   = 4 * 4096;
  localparam logic [31:0] BASE64   = 32'h2000_0000;
  localparam longint      SPAN64   = 8 * 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
  logic        req_ready, resp_valid, resp_err, dbg_state;
  logic [31:0] req_addr = '0, req_wdata = '0, resp_rdata;
  logic [2:0]  req_size = '0;

  logic        req_valid_64 = 1'b0, req_we_64 = 1'b0, resp_ready_64 = 1'b1;
  logic        req_ready_64, resp_valid_64, resp_err_64, dbg_state_64;
  logic [31:0] req_addr_64 = '0;
  logic [63:0] req_wdata_64 = '0, resp_rdata_64;
  logic [2:0]  req_size_64 = '0;

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];
  bit [7:0] model_mem [int unsigned];

  always #5 clk = ~clk;

  data_ram_bank #(.DATA_W(32), .DEPTH_LOG2(12), .ADDR_W(32), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state));

  data_ram_bank #(.DATA_W(64), .DEPTH_LOG2(6), .ADDR_W(32), .BASE_ADDR(BASE64)) u_dut64 (
    .clk(clk), .rst(rst), .req_valid(req_valid_64), .req_ready(req_ready_64), .req_we(req_we_64),
    .req_addr(req_addr_64), .req_size(req_size_64), .req_wdata(req_wdata_64),
    .resp_valid(resp_valid_64), .resp_ready(resp_ready_64), .resp_rdata(resp_rdata_64),
    .resp_err(resp_err_64), .dbg_state(dbg_state_64));

  initial begin
    #500_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Reference: memory as individual bytes; a request touches 2^size[1:0] consecutive bytes.
  function automatic void ref_model(input bit we, input logic [31:0] addr, input logic [2:0] size,
                                    input logic [63:0] wdata, input int dw, input logic [31:0] base,
                                    input longint span, output logic [63:0] rdata, output bit err);
    int nb;
    longint off;
    logic [63:0] v;
    nb = 1 << size[1:0];
    off = longint'(addr) - longint'(base);
    err = (off < 0) || (off >= span) || (size == 3'd7) ||
          (dw == 32 && (size == 3'd3 || size == 3'd6)) || ((addr % nb) != 0);
    rdata = '0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < nb; i++) model_mem[addr + i] = wdata[8*i +: 8];
      return;
    end
    v = '0;
    for (int i = 0; i < nb; i++) v = v | (64'(model_mem[addr + i]) << (8 * i));
    if (!size[2] && nb < 8 && v[nb*8-1]) v = v | ~((64'd1 << (nb * 8)) - 64'd1);
    if (dw == 32) v = v & 64'hFFFF_FFFF;
    rdata = v;
  endfunction

  task automatic xact32(input bit we, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
    resp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    rd = resp_rdata; er = resp_err;
  endtask

  task automatic run32(input bit we, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                       output int lat, output logic [31:0] exp_rd, output logic exp_er);
    logic [63:0] m_rd;
    bit m_er;
    ref_model(we, addr, size, {32'h0, wdata}, 32, BASE, SPAN32, m_rd, m_er);
    exp_rd = m_rd[31:0]; exp_er = m_er;
    xact32(we, addr, size, wdata, rd, er, lat);
  endtask

  task automatic xact64(input bit we, input logic [31:0] addr, input logic [2:0] size,
                        input logic [63:0] wdata, output logic [63:0] rd, output logic er,
                        output int lat);
    int n;
    @(negedge clk);
    req_valid_64 = 1'b1; req_we_64 = we; req_addr_64 = addr; req_size_64 = size;
    req_wdata_64 = wdata; resp_ready_64 = 1'b1;
    n = 0;
    while (!req_ready_64 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid_64 = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!resp_valid_64 && lat < 20) begin @(negedge clk); lat++; end
    rd = resp_rdata_64; er = resp_err_64;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid_64 !== 1'b0) begin failures++; $display("FAIL reset_valid64 got=%b exp=0", resp_valid_64); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] rd, erd; logic er, eer; int lat;
    run32(1'b1, BASE + 32'h10, 3'b010, 32'h1234_5678, rd, er, lat, erd, eer);
    checks++; if ({er, rd} !== 33'h0) begin failures++; $display("FAIL basic_store got=%b/%h exp=0/0", er, rd); end
    checks++; if (lat !== 0) begin failures++; $display("FAIL basic_store_lat got=%0d exp=0", lat); end
    run32(1'b0, BASE + 32'h10, 3'b010, 32'h0, rd, er, lat, erd, eer);
    checks++; if ({er, rd} !== {1'b0, 32'h1234_5678}) begin failures++; $display("FAIL basic_load got=%b/%h exp=0/12345678", er, rd); end
    checks++; if (lat !== 0) begin failures++; $display("FAIL basic_load_lat got=%0d exp=0", lat); end
  endtask

  task automatic test_lanes();
    logic [31:0] rd, erd; logic er, eer; int lat;
    run32(1'b1, BASE + 32'h13, 3'b000, 32'h5555_55AB, rd, er, lat, erd, eer);
    run32(1'b1, BASE + 32'h10, 3'b001, 32'hDEAD_80FF, rd, er, lat, erd, eer);
    checks++; if ({er, rd} !== 33'h0) begin failures++; $display("FAIL lanes_store got=%b/%h exp=0/0", er, rd); end
    run32(1'b0, BASE + 32'h10, 3'b010, 32'h0, rd, er, lat, erd, eer);
    checks++; if (rd !== 32'hAB34_80FF) begin failures++; $display("FAIL lanes_w got=%h exp=ab3480ff", rd); end
    run32(1'b0, BASE + 32'h13, 3'b000, 32'h0, rd, er, lat, erd, eer);
    checks++; if (rd !== 32'hFFFF_FFAB) begin failures++; $display("FAIL lanes_b got=%h exp=ffffffab", rd); end
    run32(1'b0, BASE + 32'h13, 3'b100, 32'h0, rd, er, lat, erd, eer);
    checks++; if (rd !== 32'h0000_00AB) begin failures++; $display("FAIL lanes_bu got=%h exp=000000ab", rd); end
    run32(1'b0, BASE + 32'h10, 3'b001, 32'h0, rd, er, lat, erd, eer);
    checks++; if (rd !== 32'hFFFF_80FF) begin failures++; $display("FAIL lanes_h got=%h exp=ffff80ff", rd); end
    run32(1'b0, BASE + 32'h12, 3'b101, 32'h0, rd, er, lat, erd, eer);
    checks++; if (rd !== 32'h0000_AB34) begin failures++; $display("FAIL lanes_hu_hi got=%h exp=0000ab34", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic er, eer; int lat;
    logic [31:0] addrs [8];
    logic [2:0]  sizes [8];
    bit          wes [8];
    addrs = '{BASE + 32'h11, BASE + 32'h12, BASE + 32'h4000, BASE - 32'h4,
              BASE + 32'h10, BASE + 32'h10, BASE + 32'h10, BASE + 32'h11};
    sizes = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b111, 3'b011, 3'b110, 3'b101};
    wes   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      run32(wes[i], addrs[i], sizes[i], 32'hFFFF_FFFF, rd, er, lat, erd, eer);
      checks++; if ({er, rd} !== {1'b1, 32'h0}) begin failures++; $display("FAIL err_case%0d got=%b/%h exp=1/0", i, er, rd); end
    end
    run32(1'b0, BASE + 32'h10, 3'b010, 32'h0, rd, er, lat, erd, eer);
    checks++; if ({er, rd} !== {1'b0, 32'hAB34_80FF}) begin failures++; $display("FAIL err_no_side_effect got=%b/%h exp=0/ab3480ff", er, rd); end
    run32(1'b0, BASE + 32'h3FFC, 3'b010, 32'h0, rd, er, lat, erd, eer);
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL err_last_word got=%b exp=0", er); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    resp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = BASE + 32'h10; req_size = 3'b010;
    @(posedge clk); #1;
    req_size = 3'b001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({resp_valid, req_ready, resp_err, resp_rdata} !== {3'b100, 32'hAB34_80FF}) begin
        failures++;
        $display("FAIL bp_hold%0d got v=%b rdy=%b e=%b d=%h exp v=1 rdy=0 e=0 d=ab3480ff",
                 i, resp_valid, req_ready, resp_err, resp_rdata);
      end
    end
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_comb got=%b exp=1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'hFFFF_80FF}) begin failures++; $display("FAIL bp_second got v=%b e=%b d=%h exp v=1 e=0 d=ffff80ff", resp_valid, resp_err, resp_rdata); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", resp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] data [16];
    logic [63:0] m_rd; bit m_er; logic [32:0] e;
    for (int i = 0; i < 16; i++) data[i] = $urandom;
    resp_ready = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (resp_valid !== 1'b1 || {resp_err, resp_rdata} !== e) begin
          failures++;
          $display("FAIL stream%0d got v=%b %b/%h exp v=1 %b/%h", i - 1, resp_valid, resp_err, resp_rdata, e[32], e[31:0]);
        end
      end
      if (i < 32) begin
        req_valid = 1'b1; req_we = (i < 16); req_size = 3'b010;
        req_addr = BASE + 32'h200 + 32'(4 * (i % 16)); req_wdata = data[i % 16];
        ref_model(req_we, req_addr, req_size, {32'h0, req_wdata}, 32, BASE, SPAN32, m_rd, m_er);
        exp_q.push_back({m_er, m_rd[31:0]});
      end else begin
        req_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL stream_end got v=%b q=%0d exp v=0 q=0", resp_valid, exp_q.size()); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr; logic er, eer; int lat, r;
    bit we; logic [2:0] size;
    for (int w = 0; w < 16; w++) begin
      run32(1'b1, BASE + 32'h100 + 32'(4 * w), 3'b010, $urandom, rd, er, lat, erd, eer);
    end
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      size = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      if (r == 0) addr = BASE + 32'h4000 + 32'($urandom_range(0, 15));
      else if (r == 1) addr = BASE - 32'($urandom_range(1, 8));
      else addr = BASE + 32'h100 + 32'($urandom_range(0, 63));
      run32(we, addr, size, $urandom, rd, er, lat, erd, eer);
      checks++;
      if ({er, rd} !== {eer, erd} || lat != 0) begin
        failures++;
        $display("FAIL rand%0d we=%b a=%h s=%0d got=%b/%h lat=%0d exp=%b/%h lat=0", n, we, addr, size, er, rd, lat, eer, erd);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic er, eer; int lat;
    @(negedge clk);
    resp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = BASE + 32'h10; req_size = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pending got=%b exp=1", resp_valid); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({resp_valid, req_ready, resp_rdata} !== {2'b01, 32'h0}) begin failures++; $display("FAIL rstmid_async got v=%b rdy=%b d=%h exp v=0 rdy=1 d=0", resp_valid, req_ready, resp_rdata); end
    @(negedge clk);
    rst = 1'b0; resp_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_dropped got=%b exp=0", resp_valid); end
    end
    run32(1'b0, BASE + 32'h10, 3'b010, 32'h0, rd, er, lat, erd, eer);
    checks++; if ({er, rd} !== {1'b0, 32'hAB34_80FF}) begin failures++; $display("FAIL rstmid_retain got=%b/%h exp=0/ab3480ff", er, rd); end
    run32(1'b0, BASE + 32'h104, 3'b010, 32'h0, rd, er, lat, erd, eer);
    checks++; if ({er, rd} !== {eer, erd}) begin failures++; $display("FAIL rstmid_retain2 got=%b/%h exp=%b/%h", er, rd, eer, erd); end
  endtask

  task automatic test_dw64();
    logic [63:0] rd; logic er; int lat;
    logic [31:0] offs [7];
    logic [2:0]  sizes [7];
    logic [64:0] exps [7];
    offs  = '{32'h8, 32'hC, 32'h8, 32'h8, 32'hE, 32'hF, 32'h4};
    sizes = '{3'b011, 3'b110, 3'b010, 3'b011, 3'b101, 3'b000, 3'b011};
    exps  = '{65'h0, {1'b0, 64'h0000_0000_0123_4567}, {1'b0, 64'hFFFF_FFFF_89AB_CDEF},
              {1'b0, 64'h0123_4567_89AB_CDEF}, {1'b0, 64'h0000_0000_0000_0123},
              {1'b0, 64'h0000_0000_0000_0001}, {1'b1, 64'h0}};
    for (int i = 0; i < 7; i++) begin
      xact64(i == 0, BASE64 + offs[i], sizes[i], 64'h0123_4567_89AB_CDEF, rd, er, lat);
      checks++; if ({er, rd} !== exps[i] || lat != 0) begin failures++; $display("FAIL dw64_case%0d got=%b/%h lat=%0d exp=%b/%h", i, er, rd, lat, exps[i][64], exps[i][63:0]); end
    end
    xact64(1'b0, BASE64 + 32'(SPAN64), 3'b011, 64'h0, rd, er, lat);
    checks++; if ({er, rd} !== {1'b1, 64'h0}) begin failures++; $display("FAIL dw64_range got=%b/%h exp=1/0", er, rd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lanes();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_dw64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
